vxe_mem_hub_cu_ds_arb: RTL
==========================

Name: vxe_mem_hub_cu_ds_arb

Overview:
- Arbitrates between master ports 0 and 1 for one client's downstream (response) path.
- Drives the master-select input of vxe_mem_hub_cu_ds and watches that block's output-side write strobes.
- Switches masters only at response boundaries, when no data beats are outstanding, so status and data from different masters never interleave.
- Round-robin between masters, with a per-grant burst limit for fairness.

Parameters:
- MAX_BURST, 4: responses (status pops) allowed per grant before a forced switch, if the other master is waiting; range 1..255.
- PEND_W, 4: width of the outstanding-data-beat counter.
- DFLAG_BIT, 8: bit of the 9-bit response status that marks "one data beat follows".

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- i_m0_rss_vld  in  1  master 0 response status FIFO non-empty
- i_m1_rss_vld  in  1  master 1 response status FIFO non-empty
- i_rss  in  9  status currently forwarded by cu_ds (its o_rss)
- i_rss_wr  in  1  cu_ds writes status to client (its o_rss_wr)
- i_rsd_wr  in  1  cu_ds writes data beat to client (its o_rsd_wr)
- o_m_sel  out  1  master select to cu_ds
- o_busy  out  1  data beats outstanding (pend != 0)
- o_err  out  1  sticky protocol error

Behaviour:
- Interface: one clock, clk. Reset nrst is asynchronous, active-low.
- Reset values: o_m_sel=0, pend=0, bcnt=0, o_busy=0, o_err=0.
- Per-cycle terms:
  - sflag = i_rss_wr & i_rss[DFLAG_BIT]
  - pend_nx = pend + sflag - i_rsd_wr (computed at PEND_W+1 bits)
  - cur_vld = valid of the selected master; oth_vld = valid of the other master.
- Pend counter:
  - Register pend <= pend_nx.
  - Underflow (pend=0, i_rsd_wr, !sflag): o_err<=1, pend stays 0.
  - Overflow (pend all-ones, sflag, !i_rsd_wr): o_err<=1, pend saturates.
  - o_err clears only on reset.
- Burst counter bcnt (8b):
  - Increments on i_rss_wr, saturating at MAX_BURST.
  - Reset to 0 on every switch.
- Switch decision, evaluated each cycle:
  - sw = (pend_nx==0) & oth_vld & (!cur_vld | bcnt_nx>=MAX_BURST), where bcnt_nx is bcnt after this cycle's increment.
  - On sw: o_m_sel toggles at the clock edge and bcnt<=0.
  - A pop in the same cycle is attributed to the old master. It is legal because pend_nx==0 guarantees the response is complete.
- Status-before-data: cu_ds may pop the next status before the previous data beat. pend tracks this, and switching waits until every beat is drained.
- Simultaneous sflag and i_rsd_wr: net zero change to pend.
- Neither master valid: hold o_m_sel. Idle holds the last grant (no return to master 0).
- Only one master ever valid: o_m_sel stays on it; the burst limit has no effect.
- Both masters continuously valid, no data: grant alternates every MAX_BURST status pops.
- Latency: the new o_m_sel is visible the cycle after the decision. cu_ds then forwards from the new master combinationally.
- o_busy = (pend != 0), registered.
- Reset mid-transfer: all state is cleared asynchronously. Outstanding beats are forgotten; the environment flushes FIFOs on the same reset.

Optional Feature:
- Macro VXE_CU_DS_ARB_STATS_EN.
- When defined:
  - Adds outputs o_m0_resp_cnt[31:0] and o_m1_resp_cnt[31:0]. Each counts status pops attributed to its master (i_rss_wr while o_m_sel selects it) and wraps at 2^32.
  - Adds o_sw_cnt[15:0], which counts switches and wraps at 2^16.
  - All reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package vxe_mem_hub_pkg holds:
  - response status width (9) and data width (64);
  - the DFLAG bit position;
  - master index constants VXE_M0=1'b0, VXE_M1=1'b1.
- The burst/pend decision stays inline.
- One natural sub-module: vxe_sat_counter (saturating up/down counter with under/overflow flags), used for pend.

Test Plan:
- Reset, then m0 only: 6 flagged statuses, each followed by its data beat. Required: o_m_sel stays 0; o_busy pulses; o_err=0.
- MAX_BURST=4, both masters continuously valid, unflagged statuses. Required: o_m_sel toggles after pops 4, 8, 12; with STATS_EN, per-master counts are 4/4/4 pattern and o_sw_cnt=3.
- m0 pops 2 flagged statuses back-to-back (pend=2) while m1 is valid. Required: no switch until the 2nd i_rsd_wr; o_m_sel flips the following cycle.
- i_rsd_wr pulsed with pend=0. Required: o_err=1 and stays 1; pend remains 0.
- Same-cycle sflag and i_rsd_wr with pend=1. Required: pend stays 1 and no switch.
- nrst asserted while pend=3 and o_m_sel=1. Required: immediately o_m_sel=0, o_busy=0, o_err=0.

Source files
------------

// File: rtl/vxe_mem_hub_pkg.sv
// vxe_mem_hub_pkg
//   Shared constants for the memory hub client-side blocks: response status
//   and data widths, the status bit marking "one data beat follows", and the
//   master index encodings used by the downstream select.
package vxe_mem_hub_pkg;

    localparam int unsigned VXE_RSS_W     = 9;
    localparam int unsigned VXE_RSD_W     = 64;
    localparam int unsigned VXE_DFLAG_BIT = 8;

    localparam logic VXE_M0 = 1'b0;
    localparam logic VXE_M1 = 1'b1;

endpackage

// File: rtl/vxe_sat_counter.sv
// vxe_sat_counter
//   Saturating up/down counter. Simultaneous inc and dec cancel. A dec at
//   zero or an inc at all-ones holds the value and raises the matching flag
//   for that cycle.
// Ports:
//   clk, nrst  clock, asynchronous active-low reset
//   inc, dec   count up / count down requests
//   q          current count (registered)
//   d          count after this cycle (combinational)
//   unf, ovf   this cycle's request would underflow / overflow
module vxe_sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] q,
    output logic [W-1:0] d,
    output logic         unf,
    output logic         ovf
);

    localparam logic [W-1:0] ONE = W'(1);

    always_comb begin
        unf = dec & ~inc & (q == '0);
        ovf = inc & ~dec & (q == '1);
        d   = q;
        if (inc && !dec && !ovf) begin
            d = q + ONE;
        end else if (dec && !inc && !unf) begin
            d = q - ONE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/vxe_mem_hub_cu_ds_arb.sv
// vxe_mem_hub_cu_ds_arb
//   Round-robin master select for one client's downstream response path.
//   The grant only moves at a response boundary (no data beats outstanding),
//   and a grant holding master is forced off after MAX_BURST status pops when
//   the other master is waiting.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   i_m0_rss_vld, i_m1_rss_vld master status FIFOs non-empty
//   i_rss, i_rss_wr, i_rsd_wr  status / status strobe / data strobe seen by client
//   o_m_sel                    master select to cu_ds
//   o_busy                     data beats outstanding
//   o_err                      sticky pend under/overflow
// Optional: `define VXE_CU_DS_ARB_STATS_EN adds o_m0_resp_cnt, o_m1_resp_cnt
//   (per-master status pops) and o_sw_cnt (grant switches).
module vxe_mem_hub_cu_ds_arb
    import vxe_mem_hub_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned PEND_W    = 4,
    parameter int unsigned DFLAG_BIT = VXE_DFLAG_BIT
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 i_m0_rss_vld,
    input  logic                 i_m1_rss_vld,
    input  logic [VXE_RSS_W-1:0] i_rss,
    input  logic                 i_rss_wr,
    input  logic                 i_rsd_wr,
`ifdef VXE_CU_DS_ARB_STATS_EN
    output logic [31:0]          o_m0_resp_cnt,
    output logic [31:0]          o_m1_resp_cnt,
    output logic [15:0]          o_sw_cnt,
`endif
    output logic                 o_m_sel,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int unsigned PW1  = PEND_W + 1;
    localparam logic [7:0]  MAXB = 8'(MAX_BURST);

    logic              sflag;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              pend_unf;
    logic              pend_ovf;
    logic [PEND_W:0]   pend_nx;
    logic              cur_vld;
    logic              oth_vld;
    logic [7:0]        bcnt;
    logic [7:0]        bcnt_nx;
    logic              sw;
    logic              unused_rss;

    // Only the data flag matters here; other status bits pass straight to the client.
    assign unused_rss = ^i_rss;

    assign sflag = i_rss_wr & i_rss[DFLAG_BIT];

    vxe_sat_counter #(
        .W (PEND_W)
    ) u_pend (
        .clk  (clk),
        .nrst (nrst),
        .inc  (sflag),
        .dec  (i_rsd_wr),
        .q    (pend_q),
        .d    (pend_d),
        .unf  (pend_unf),
        .ovf  (pend_ovf)
    );

    // Unsaturated one-bit-wider sum: an under/overflow cycle never reads as zero,
    // so it can never open a switch window.
    assign pend_nx = {1'b0, pend_q} + PW1'(sflag) - PW1'(i_rsd_wr);

    assign cur_vld = (o_m_sel == VXE_M1) ? i_m1_rss_vld : i_m0_rss_vld;
    assign oth_vld = (o_m_sel == VXE_M1) ? i_m0_rss_vld : i_m1_rss_vld;

    always_comb begin
        bcnt_nx = bcnt;
        if (i_rss_wr && (bcnt < MAXB)) begin
            bcnt_nx = bcnt + 8'd1;
        end
    end

    // A pop in the switching cycle still belongs to the old master; pend_nx==0
    // guarantees its response is complete.
    assign sw = (pend_nx == '0) & oth_vld & (~cur_vld | (bcnt_nx >= MAXB));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_m_sel <= VXE_M0;
            bcnt    <= '0;
            o_busy  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (sw) begin
                o_m_sel <= ~o_m_sel;
            end
            bcnt   <= sw ? '0 : bcnt_nx;
            o_busy <= (pend_d != '0);
            o_err  <= o_err | pend_unf | pend_ovf;
        end
    end

`ifdef VXE_CU_DS_ARB_STATS_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_m0_resp_cnt <= '0;
            o_m1_resp_cnt <= '0;
            o_sw_cnt      <= '0;
        end else begin
            if (i_rss_wr && (o_m_sel == VXE_M0)) begin
                o_m0_resp_cnt <= o_m0_resp_cnt + 32'd1;
            end
            if (i_rss_wr && (o_m_sel == VXE_M1)) begin
                o_m1_resp_cnt <= o_m1_resp_cnt + 32'd1;
            end
            if (sw) begin
                o_sw_cnt <= o_sw_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
